data_memory_param: RTL and testbench
====================================

# data_memory_param

Parametrised single-port data memory with asynchronous active-low reset, a self-timed initialisation sweep and write-rejection reporting. After reset, and on request, a sequencer fills every word with a configurable value, one word per clock. Once the sweep completes, the block serves combinational reads and clocked writes to the pipeline's memory stage. It supersedes the fixed 8×8 data memory, adding a `ready` handshake and explicit out-of-range handling.

## Interface
- `DATA_W`, default 8: word width in bits.
- `DEPTH`, default 8: number of words, ≥2; need not be a power of two.
- `ADDR_W`, default 8: address port width; must satisfy 2^ADDR_W ≥ DEPTH.
- `INIT_VALUE`, default 8'h07 (`DATA_W` bits): value written to every word by the sweep.

- `clk`  in  1  single clock; all state updates on the rising edge.
- `init_n`  in  1  reset, asynchronous and active-low.
- `clear`  in  1  synchronous request to re-run the initialisation sweep.
- `address`  in  `ADDR_W`  read/write address.
- `data`  in  `DATA_W`  write data.
- `wren`  in  1  write enable.
- `q`  out  `DATA_W`  read data.
- `ready`  out  1  high when the memory accepts writes and returns valid reads.
- `wr_err`  out  1  registered one-cycle pulse per rejected write.

## Operation
- **States:**
  - SWEEP: the init sequencer owns the array.
  - READY: normal access.
- **Sweep counter:** `sweep_addr`, width clog2(DEPTH).
- **Reset (`init_n` low), applied asynchronously:**
  - state=SWEEP, `sweep_addr`=0, `ready`=0, `wr_err`=0.
  - Array contents are not reset; the sweep rewrites them.
- **SWEEP, each edge:**
  - mem[`sweep_addr`] ← `INIT_VALUE`, then `sweep_addr` increments.
  - The edge that writes word DEPTH-1 moves the state to READY and sets `ready`=1.
- **READY, write accepted:** if `wren`=1, `clear`=0 and `address` < DEPTH, then mem[`address`] ← `data`.
- **READY, `clear`=1:**
  - Next edge: state=SWEEP, `sweep_addr`=0, `ready`=0.
  - No user write occurs on that edge.
- **SWEEP, `clear`=1:** sweep restarts at 0 on the next edge.
- **Rejected write:** `wren`=1 while in SWEEP, while `clear`=1, or with `address` ≥ DEPTH.
  - The array is unchanged.
  - `wr_err`=1 for the following cycle.
- **`wr_err`:** 0 on every edge with no rejected write; it is not sticky.
- **Read (combinational):** q = mem[`address`] when `ready`=1 and `address` < DEPTH; otherwise q = 0.
- **Address width:** `address` is compared at full `ADDR_W`; no truncation or wrap to DEPTH.

## Timing
- **Sweep length:** DEPTH cycles. `ready` rises on the DEPTH-th rising edge after `init_n` deasserts.
- **Reset mid-sweep or mid-operation:** `ready` and `wr_err` drop immediately (asynchronous). The sweep restarts from word 0 after release.
- **`clear` to `ready`:**
  - `ready` falls on the edge that samples `clear`=1.
  - `ready` returns DEPTH edges after that, provided `clear` was not re-asserted.
- **Write latency:** the written value is visible on q in the cycle after the write edge.
- **Same-cycle read of the write address:** returns the old contents (no bypass).
- **Read latency:** 0 cycles from `address` to q.
- **Simultaneous `clear` and `wren` in READY:** `clear` wins; the write is dropped and `wr_err` pulses.
- **Back-to-back writes:** one accepted write per cycle.
- **Last word (DEPTH-1):** writable; `address` = DEPTH is out of range.

## Test plan
- **Reset and sweep:** hold `init_n` low, release, then read all words (DEPTH=8, `INIT_VALUE`=8'h07).
  - `ready` is 0 for 8 edges, then 1.
  - Every word reads 8'h07.
- **Write/read:** in READY, write 8'hA5 to address 3 and 8'h3C to address 7, then read both.
  - q=8'hA5 and q=8'h3C respectively, in the cycle after each write.
  - Address 3 reads 8'h07 in the write cycle itself.
- **Out of range:** DEPTH=6, `ADDR_W`=8; write 8'hFF to address 6 and to address 200.
  - `wr_err` pulses 1 cycle for each write.
  - q=0 at both addresses.
  - Words 0–5 are unchanged.
- **Write during sweep:** assert `wren` with address 2 and data 8'h11 in the 3rd sweep cycle.
  - `wr_err` pulses.
  - After `ready`, address 2 reads 8'h07.
- **`clear` collision and reset mid-sweep:**
  - In READY, assert `clear` and `wren` together (address 1, 8'h22): `ready` falls, `wr_err` pulses, and after re-sweep address 1 reads 8'h07.
  - Then pull `init_n` low mid-sweep: `ready` stays 0 and rises 8 edges after release.

Source files
------------

// File: rtl/data_memory_param.sv
// data_memory_param: single-port data memory with a self-timed
// init sweep, combinational reads and rejected-write reporting.
module data_memory_param #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 8,
  parameter logic [DATA_W-1:0] INIT_VALUE = DATA_W'(8'h07)
) (
  input  logic              clk,
  input  logic              init_n,
  input  logic              clear,
  input  logic [ADDR_W-1:0] address,
  input  logic [DATA_W-1:0] data,
  input  logic              wren,
  output logic [DATA_W-1:0] q,
  output logic              ready,
  output logic              wr_err
);
  localparam int SW = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LIM =
    (ADDR_W+1)'(DEPTH);
  localparam logic [SW-1:0] LAST = SW'(DEPTH-1);

  typedef enum logic {SWEEP, READY} state_t;

  state_t            state;
  logic [SW-1:0]     sweep_addr;
  logic [DATA_W-1:0] mem [DEPTH];
  logic [SW-1:0]     idx;
  logic              in_range;
  logic              wr_ok;
  logic              wr_bad;
  logic              sweep_we;

  // Full-width compare: no wrap of high addresses onto the array
  assign in_range = {1'b0, address} < LIM;
  assign idx      = address[SW-1:0];
  assign wr_ok    = wren && !clear && in_range
                    && state == READY;
  assign wr_bad   = wren && !wr_ok;
  assign sweep_we = init_n && !clear && state == SWEEP;
  assign q        = (ready && in_range) ? mem[idx] : '0;

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      state      <= SWEEP;
      sweep_addr <= '0;
      ready      <= 1'b0;
      wr_err     <= 1'b0;
    end else begin
      wr_err <= wr_bad;
      if (clear) begin
        state      <= SWEEP;
        sweep_addr <= '0;
        ready      <= 1'b0;
      end else begin
        unique case (state)
          SWEEP: begin
            sweep_addr <= sweep_addr + 1'b1;
            if (sweep_addr == LAST) begin
              state      <= READY;
              ready      <= 1'b1;
              sweep_addr <= '0;
            end
          end
          READY: ;
          default: state <= SWEEP;
        endcase
      end
    end
  end

  // Array has no reset; the sweep owns initialisation
  always_ff @(posedge clk) begin
    if (sweep_we)
      mem[sweep_addr] <= INIT_VALUE;
    else if (wr_ok)
      mem[idx] <= data;
  end

endmodule

// File: tb/tb_data_memory_param.sv
// tb_data_memory_param: scoreboard bench for data_memory_param,
// default 8-word instance plus a 6-word out-of-range instance.
module tb_data_memory_param;
  logic       clk;
  logic       init_n;
  logic       clear;
  logic [7:0] addr, din, addr6, din6;
  logic       wren, wren6;
  logic [7:0] q, q6;
  logic       rdy, rdy6, werr, werr6;

  int total = 0;
  int bad   = 0;

  typedef struct {
    int         sel;
    logic [7:0] exp;
    string      nm;
  } chk_t;

  chk_t sb[$];

  data_memory_param dut (
    .clk(clk), .init_n(init_n), .clear(clear),
    .address(addr), .data(din), .wren(wren),
    .q(q), .ready(rdy), .wr_err(werr)
  );

  data_memory_param #(.DEPTH(6)) dut6 (
    .clk(clk), .init_n(init_n), .clear(clear),
    .address(addr6), .data(din6), .wren(wren6),
    .q(q6), .ready(rdy6), .wr_err(werr6)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic expect_v(input int sel,
                          input logic [7:0] e,
                          input string nm);
    chk_t c;
    c.sel = sel;
    c.exp = e;
    c.nm  = nm;
    sb.push_back(c);
  endtask

  task automatic nx();
    @(negedge clk);
  endtask

  // Monitor: mid-cycle, compare every queued expectation
  initial begin
    chk_t       c;
    logic [7:0] act;
    forever begin
      @(negedge clk);
      #2;
      while (sb.size() > 0) begin
        c = sb.pop_front();
        case (c.sel)
          0:       act = q;
          1:       act = 8'(rdy);
          2:       act = 8'(werr);
          3:       act = q6;
          4:       act = 8'(rdy6);
          default: act = 8'(werr6);
        endcase
        total++;
        if (act !== c.exp) begin
          bad++;
          $display("FAIL %s: got %h expected %h",
                   c.nm, act, c.exp);
        end
      end
    end
  end

  initial begin
    init_n = 1'b0;
    clear  = 1'b0;
    addr   = 8'd0;
    din    = 8'd0;
    wren   = 1'b0;
    addr6  = 8'd0;
    din6   = 8'd0;
    wren6  = 1'b0;

    nx();
    nx();
    expect_v(1, 8'd0, "rst_ready");
    expect_v(2, 8'd0, "rst_wr_err");
    expect_v(0, 8'd0, "rst_q");
    expect_v(4, 8'd0, "rst_ready6");
    nx();

    // Release, count sweep edges, write into word 2 mid-sweep
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) nx();
      init_n = 1'b1;
      wren   = (i == 2);
      addr   = 8'd2;
      din    = 8'h11;
      expect_v(1, 8'(i == 8), "sweep_ready");
      expect_v(4, 8'(i >= 6), "sweep_ready6");
      expect_v(2, 8'(i == 3), "sweep_wr_err");
    end

    for (int a = 0; a < 8; a++) begin
      nx();
      addr  = 8'(a);
      addr6 = 8'(a);
      expect_v(0, 8'h07, "sweep_word");
      expect_v(3, (a < 6) ? 8'h07 : 8'h00, "sweep6_word");
    end

    nx();
    addr = 8'd3; din = 8'hA5; wren = 1'b1;
    expect_v(0, 8'h07, "wr_same_cycle");
    nx();
    wren = 1'b0;
    expect_v(0, 8'hA5, "wr_a5");
    expect_v(2, 8'h00, "wr_ok_no_err");
    nx();
    addr = 8'd7; din = 8'h3C; wren = 1'b1;
    expect_v(0, 8'h07, "wr7_old");
    nx();
    wren = 1'b0;
    expect_v(0, 8'h3C, "wr_3c");
    nx();
    addr = 8'd8;
    expect_v(0, 8'h00, "q_addr8");

    nx();
    addr6 = 8'd6; din6 = 8'hFF; wren6 = 1'b1;
    expect_v(3, 8'h00, "oor6_q");
    nx();
    addr6 = 8'd200;
    expect_v(5, 8'h01, "oor6_err");
    expect_v(3, 8'h00, "oor200_q");
    nx();
    wren6 = 1'b0;
    addr6 = 8'd0;
    expect_v(5, 8'h01, "oor200_err");
    nx();
    expect_v(5, 8'h00, "err_not_sticky");
    for (int a = 0; a < 6; a++) begin
      nx();
      addr6 = 8'(a);
      expect_v(3, 8'h07, "oor6_unchanged");
    end
    nx();
    addr6 = 8'd5; din6 = 8'h5A; wren6 = 1'b1;
    nx();
    wren6 = 1'b0;
    expect_v(3, 8'h5A, "last_word");
    expect_v(5, 8'h00, "last_word_err");

    // clear collides with a write
    nx();
    clear = 1'b1; wren = 1'b1;
    addr = 8'd1; din = 8'h22;
    expect_v(1, 8'h01, "pre_clear_ready");
    nx();
    clear = 1'b0; wren = 1'b0;
    expect_v(1, 8'h00, "clear_ready_fall");
    expect_v(2, 8'h01, "clear_wr_err");
    expect_v(4, 8'h00, "clear_ready6_fall");
    for (int j = 1; j <= 8; j++) begin
      nx();
      expect_v(1, 8'(j == 8), "clear_resweep");
      expect_v(4, 8'(j >= 6), "clear_resweep6");
    end
    nx();
    expect_v(0, 8'h07, "clear_addr1");

    // Async reset while a rejected-write pulse is pending
    nx();
    addr = 8'd9; wren = 1'b1;
    nx();
    wren   = 1'b0;
    addr   = 8'd1;
    init_n = 1'b0;
    expect_v(1, 8'h00, "async_ready");
    expect_v(2, 8'h00, "async_wr_err");
    expect_v(0, 8'h00, "async_q");
    nx();
    init_n = 1'b1;
    for (int j = 1; j <= 3; j++) begin
      nx();
      expect_v(1, 8'h00, "sweep_pre_rst");
    end
    init_n = 1'b0;
    nx();
    init_n = 1'b1;
    expect_v(1, 8'h00, "mid_rst_ready");
    for (int j = 1; j <= 8; j++) begin
      nx();
      expect_v(1, 8'(j == 8), "mid_rst_resweep");
      expect_v(4, 8'(j >= 6), "mid_rst_resweep6");
    end
    nx();
    addr = 8'd3;
    expect_v(0, 8'h07, "final_addr3");

    nx();
    nx();
    if (sb.size() != 0) begin
      total++;
      bad++;
      $display("FAIL drain: got %0d expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
